shift_register_universal_n: RTL and testbench

Parametrised universal shift register: the next-generation member of the shift-register family. It merges SISO, SIPO, PISO and PIPO behaviour into one N-bit register with an opcode-selected operation set, and adds rotate and arithmetic shift. It also adds an automatic full-duplex frame sequencer that loads a word, shifts it out serially and captures N incoming bits, then signals completion. It sits between serial peripherals (SPI-style links, LED/74HC595 drivers) and the parallel datapath.

---
 rtl/shift_register_universal_n.sv | 98 +++++++++
 tb/tb_shift_register_universal_n.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_register_universal_n.sv
// Universal N-bit shift register with an opcode-driven operation set
// (shift, rotate, arithmetic shift, load, clear) and a full-duplex
// frame sequencer. The sequencer loads a word, shifts it out serially
// while capturing N incoming bits, then pulses done.
module shift_register_universal_n #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset_p,
    input  logic         en,
    input  logic [2:0]   op,
    input  logic [N-1:0] d,
    input  logic         sin,
    input  logic         start,
    input  logic         dir,
    input  logic         rd_en,
    output logic [N-1:0] q,
    output logic         sout,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(N + 1);

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_SR   = 3'b001;
    localparam logic [2:0] OP_SL   = 3'b010;
    localparam logic [2:0] OP_ROR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_ASR  = 3'b101;
    localparam logic [2:0] OP_LOAD = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  sr;
    logic          dir_r;
    logic [CW-1:0] cnt;
    logic          last_shift;

    // The N-th shift of a frame is the one taken while cnt holds N-1.
    assign last_shift = (state == SHIFT) && (cnt == CW'(N - 1));

    // State register for the frame sequencer.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic: start is only honoured in IDLE, so a frame cannot restart.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)      state_nxt = SHIFT;
            SHIFT:   if (last_shift) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Datapath: frame load/shift and op execution. Start takes priority over en.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            sr    <= '0;
            dir_r <= 1'b1;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == SHIFT) begin
                sr   <= dir_r ? {sin, sr[N-1:1]} : {sr[N-2:0], sin};
                cnt  <= cnt + CW'(1);
                done <= last_shift;
            end else if (start) begin
                sr    <= d;
                dir_r <= dir;
                cnt   <= '0;
            end else if (en) begin
                case (op)
                    OP_SR:   begin sr <= {sin, sr[N-1:1]};      dir_r <= 1'b1; end
                    OP_SL:   begin sr <= {sr[N-2:0], sin};      dir_r <= 1'b0; end
                    OP_ROR:  begin sr <= {sr[0], sr[N-1:1]};    dir_r <= 1'b1; end
                    OP_ROL:  begin sr <= {sr[N-2:0], sr[N-1]};  dir_r <= 1'b0; end
                    OP_ASR:  begin sr <= {sr[N-1], sr[N-1:1]};  dir_r <= 1'b1; end
                    OP_LOAD: sr <= d;
                    OP_CLR:  sr <= '0;
                    OP_HOLD: sr <= sr;
                    default: sr <= sr;
                endcase
            end
        end
    end

    assign busy = (state == SHIFT);
    assign sout = dir_r ? sr[0] : sr[N-1];
    assign q    = rd_en ? sr : {N{1'bz}};

endmodule

// File: tb/tb_shift_register_universal_n.sv
// Directed bench for shift_register_universal_n. A countdown-based model
// tracks the register contents; a negedge process compares every output
// on every cycle, and literal expectations from hand calculation pin the
// model. q is pulled up so a released bus reads as all ones.
module tb_shift_register_universal_n;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset_p = 1'b1;
    logic         en = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [N-1:0] d = '0;
    logic         sin = 1'b0;
    logic         start = 1'b0;
    logic         dir = 1'b0;
    logic         rd_en = 1'b1;
    wire  [N-1:0] q;
    logic         sout, busy, done;

    int checks = 0;
    int errors = 0;

    shift_register_universal_n #(.N(N)) dut (
        .clk(clk), .reset_p(reset_p), .en(en), .op(op), .d(d), .sin(sin),
        .start(start), .dir(dir), .rd_en(rd_en), .q(q), .sout(sout),
        .busy(busy), .done(done)
    );

    for (genvar gi = 0; gi < N; gi++) begin : g_pu
        pullup (q[gi]);
    end

    always #5 clk = ~clk;

    // Model: m_left counts remaining frame shifts; nonzero means busy.
    logic [N-1:0] m_reg;
    logic         m_dir;
    int           m_left;
    logic         m_done;

    always @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            m_reg = '0; m_dir = 1'b1; m_left = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                if (m_dir) m_reg = (N'(sin) << (N - 1)) | (m_reg >> 1);
                else       m_reg = (m_reg << 1) | N'(sin);
                m_left = m_left - 1;
                if (m_left == 0) m_done = 1'b1;
            end else if (start) begin
                m_reg = d; m_dir = dir; m_left = N;
            end else if (en) begin
                case (op)
                    3'd1: begin m_reg = (N'(sin) << (N - 1)) | (m_reg >> 1); m_dir = 1'b1; end
                    3'd2: begin m_reg = (m_reg << 1) | N'(sin);               m_dir = 1'b0; end
                    3'd3: begin m_reg = (m_reg >> 1) | (m_reg << (N - 1));    m_dir = 1'b1; end
                    3'd4: begin m_reg = (m_reg << 1) | (m_reg >> (N - 1));    m_dir = 1'b0; end
                    3'd5: begin m_reg = N'($signed(m_reg) >>> 1);             m_dir = 1'b1; end
                    3'd6: m_reg = d;
                    3'd7: m_reg = '0;
                    default: ;
                endcase
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        logic [N-1:0] exp_q;
        logic         exp_sout;
        exp_q    = rd_en ? m_reg : {N{1'b1}};
        exp_sout = m_dir ? m_reg[0] : m_reg[N-1];
        checks++;
        if (q !== exp_q || sout !== exp_sout || busy !== (m_left > 0) || done !== m_done) begin
            errors++;
            $display("FAIL model_cmp t=%0t q=%h/%h sout=%b/%b busy=%b/%b done=%b/%b",
                     $time, q, exp_q, sout, exp_sout, busy, (m_left > 0), done, m_done);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp_v);
        end
    endtask

    task automatic do_op(input logic [2:0] o, input logic s, input logic [N-1:0] dv);
        en = 1'b1; op = o; sin = s; d = dv;
        tick();
        en = 1'b0;
    endtask

    logic [N-1:0] pat1   = 8'b0011_1001;  // sin per shift, bit i = shift i+1
    logic [N-1:0] sout1  = 8'b1010_0101;  // expected sout, bit i before shift i+1
    logic [N-1:0] sout2  = 8'b0011_1100;
    int done_cnt;

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_q", q, 8'h00);
        chk("rst_flags", {5'd0, busy, done, sout}, 8'h00);
        rd_en = 1'b0; #1;
        chk("rst_q_released", q, 8'hFF);
        rd_en = 1'b1;
        reset_p = 1'b0;
        tick();

        // ASR / ROL
        do_op(3'd6, 1'b0, 8'hB4); chk("load_b4", q, 8'hB4);
        do_op(3'd5, 1'b0, 8'h00); chk("asr1", q, 8'hDA);
        do_op(3'd5, 1'b0, 8'h00); chk("asr2", q, 8'hED);
        do_op(3'd4, 1'b0, 8'h00); chk("rol", q, 8'hDB);
        chk("rol_sout", {7'd0, sout}, 8'h01);

        // ROR / SL / SR
        do_op(3'd6, 1'b0, 8'h81); chk("load_81", q, 8'h81);
        do_op(3'd3, 1'b0, 8'h00); chk("ror", q, 8'hC0);
        do_op(3'd2, 1'b1, 8'h00); chk("sl_sin1", q, 8'h81);
        do_op(3'd1, 1'b0, 8'h00); chk("sr_sin0", q, 8'h40);
        do_op(3'd0, 1'b1, 8'hFF); chk("hold", q, 8'h40);

        // Frame, LSB first
        start = 1'b1; dir = 1'b1; d = 8'hA5;
        tick();
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("f1_sout%0d", i), {7'd0, sout}, {7'd0, sout1[i]});
            sin = pat1[i];
            tick();
        end
        chk("f1_done", {6'd0, busy, done}, 8'h01);
        chk("f1_q", q, 8'h39);
        tick();
        chk("f1_done_clr", {7'd0, done}, 8'h00);

        // Frame, MSB first, with start re-pulse and op mid-frame
        start = 1'b1; dir = 1'b0; d = 8'h3C;
        tick();
        start = 1'b0; dir = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("f2_sout%0d", i), {7'd0, sout}, {7'd0, sout2[N-1-i]});
            sin   = 1'($urandom_range(1));
            start = (i == 3);
            en    = (i == 5);
            op    = 3'd7;
            tick();
            if (done) done_cnt++;
        end
        start = 1'b0; en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) done_cnt++;
        end
        chk("f2_done_pulses", 8'(done_cnt), 8'd1);

        // Reset mid-frame, then a clean frame
        start = 1'b1; dir = 1'b1; d = 8'h5A;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset_p = 1'b1; #1;
        chk("mid_rst_busy", {7'd0, busy}, 8'h00);
        chk("mid_rst_q", q, 8'h00);
        done_cnt = 0;
        tick();
        reset_p = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) done_cnt++;
        end
        chk("mid_rst_no_done", 8'(done_cnt), 8'd0);
        start = 1'b1; dir = 1'b0; d = 8'hC3; sin = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < N; i++) tick();
        chk("f3_done", {6'd0, busy, done}, 8'h01);
        chk("f3_q", q, 8'hFF);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
